// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register for a 5-stage MIPS datapath.
//                Registers the decoded control, operands and register
//                specifiers for EX, detects load-use hazards (stall PC/IF-ID
//                and insert one bubble), squashes on branch/jump redirect and
//                keeps a saturating count of load-use bubbles.
//  Ports       : clk, rst_n (async, active-low)
//                id_valid_i, flush_i, decoded control (RegDst..MemWrite),
//                id_rs/rt/rd_i, id_rdata1/2_i, id_imm_i, id_pc4_i
//                ex_* registered copies, ex_valid_o,
//                hazard_stall_o (combinational), bubble_cnt_o
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic              RegDst,
  input  logic              Branch,
  input  logic              MemtoReg,
  input  logic              ALUSrc,
  input  logic              RegWrite,
  input  logic [1:0]        Jump,
  input  logic [1:0]        ALUOp,
  input  logic [1:0]        MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic [REG_W-1:0]  id_rd_i,
  input  logic [DATA_W-1:0] id_rdata1_i,
  input  logic [DATA_W-1:0] id_rdata2_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  output logic              ex_RegDst,
  output logic              ex_Branch,
  output logic              ex_MemtoReg,
  output logic              ex_ALUSrc,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_Jump,
  output logic [1:0]        ex_ALUOp,
  output logic [1:0]        ex_MemRead,
  output logic [1:0]        ex_MemWrite,
  output logic [REG_W-1:0]  ex_rs_o,
  output logic [REG_W-1:0]  ex_rt_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic [DATA_W-1:0] ex_rdata1_o,
  output logic [DATA_W-1:0] ex_rdata2_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic              ex_valid_o,
  output logic              hazard_stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam logic [REG_W-1:0] c_REG_ZERO = '0;

  logic              r_valid;
  logic              r_regdst, r_branch, r_memtoreg, r_alusrc, r_regwrite;
  logic [1:0]        r_jump, r_aluop, r_memread, r_memwrite;
  logic [REG_W-1:0]  r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_rdata1, r_rdata2, r_imm, r_pc4;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_hazard;
  logic w_bubble;

  // A load in EX always targets rt, whatever RegDst says. Register 0 is
  // hard-wired, so a load "to" $0 never creates a dependency.
  assign w_hazard = r_valid & (r_memread != 2'b00) & (r_rt != c_REG_ZERO)
                  & id_valid_i & ((r_rt == id_rs_i) | (r_rt == id_rt_i));

  // A redirect discards the ID instruction, so stalling for it is pointless.
  assign hazard_stall_o = w_hazard & ~flush_i;
  assign w_bubble       = flush_i | w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regdst   <= 1'b0;
      r_branch   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_jump     <= 2'b00;
      r_aluop    <= 2'b00;
      r_memread  <= 2'b00;
      r_memwrite <= 2'b00;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_regdst   <= 1'b0;
      r_branch   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_jump     <= 2'b00;
      r_aluop    <= 2'b00;
      r_memread  <= 2'b00;
      r_memwrite <= 2'b00;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_pc4      <= '0;
    end else begin
      // Control is captured verbatim; downstream qualifies with ex_valid_o.
      r_valid    <= id_valid_i;
      r_regdst   <= RegDst;
      r_branch   <= Branch;
      r_memtoreg <= MemtoReg;
      r_alusrc   <= ALUSrc;
      r_regwrite <= RegWrite;
      r_jump     <= Jump;
      r_aluop    <= ALUOp;
      r_memread  <= MemRead;
      r_memwrite <= MemWrite;
      r_rs       <= id_rs_i;
      r_rt       <= id_rt_i;
      r_rd       <= id_rd_i;
      r_rdata1   <= id_rdata1_i;
      r_rdata2   <= id_rdata2_i;
      r_imm      <= id_imm_i;
      r_pc4      <= id_pc4_i;
    end
  end

  // Only load-use bubbles are counted; redirect bubbles take priority and
  // leave the counter alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!flush_i && w_hazard && !(&r_bubble_cnt)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid_o   = r_valid;
  assign ex_RegDst    = r_regdst;
  assign ex_Branch    = r_branch;
  assign ex_MemtoReg  = r_memtoreg;
  assign ex_ALUSrc    = r_alusrc;
  assign ex_RegWrite  = r_regwrite;
  assign ex_Jump      = r_jump;
  assign ex_ALUOp     = r_aluop;
  assign ex_MemRead   = r_memread;
  assign ex_MemWrite  = r_memwrite;
  assign ex_rs_o      = r_rs;
  assign ex_rt_o      = r_rt;
  assign ex_rd_o      = r_rd;
  assign ex_rdata1_o  = r_rdata1;
  assign ex_rdata2_o  = r_rdata2;
  assign ex_imm_o     = r_imm;
  assign ex_pc4_o     = r_pc4;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire
